// File: rtl/indicator_bar_driver.sv
// -----------------------------------------------------------------------------
// indicator_bar_driver
//
// Purpose:
//   Consumer end of the indicator position stream. Each accepted 5-bit
//   position (0 = silence, 31 = full scale) can raise the displayed level.
//   The level falls one step every DECAY_TICKS display ticks. An optional
//   peak marker holds the highest recent position for HOLD_TICKS ticks and
//   then falls towards the level. The result is a registered 31-segment bar.
//
// Optional feature (compile-time macro INDICATOR_PEAK_HOLD_EN):
//   defined   : peak register, hold counter and peak marker segment exist.
//   undefined : no peak state. o_peak follows the level. o_bar shows only the
//               level segments. HOLD_TICKS is only range-checked.
//
// Parameters:
//   HOLD_TICKS  (1..255) ticks the peak marker is held before it falls.
//   DECAY_TICKS (1..15)  ticks per one-step fall of the level.
//
// Ports:
//   clk        in   system clock, rising edge.
//   reset      in   synchronous, active-high reset.
//   i_valid    in   i_position is valid.
//   i_ready    out  block can accept a position (IDLE only).
//   i_position in   [4:0] indicator position.
//   i_tick     in   single-cycle display timing strobe.
//   o_bar      out  [30:0] segment n lit iff n < level, or peak marker at n.
//   o_peak     out  [4:0] current peak position (level when peak is disabled).
//   o_update   out  one-cycle pulse on the cycle o_bar takes a new value.
// -----------------------------------------------------------------------------
module indicator_bar_driver #(
  parameter int HOLD_TICKS  = 24,
  parameter int DECAY_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [4:0]  i_position,
  input  logic        i_tick,
  output logic [30:0] o_bar,
  output logic [4:0]  o_peak,
  output logic        o_update
);

  // Reject configurations the counters cannot hold.
  if ((HOLD_TICKS < 1) || (HOLD_TICKS > 255)) begin : g_hold_range
    $error("indicator_bar_driver: HOLD_TICKS must be in 1..255");
  end
  if ((DECAY_TICKS < 1) || (DECAY_TICKS > 15)) begin : g_decay_range
    $error("indicator_bar_driver: DECAY_TICKS must be in 1..15");
  end

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  localparam logic [3:0] DECAY_LAST = 4'(DECAY_TICKS);

  // Control / level state
  state_t      state_q, state_d;
  logic [4:0]  pos_q, pos_d;
  logic [4:0]  level_q, level_d;
  logic [3:0]  decay_q, decay_d;
  logic        tick_pend_q, tick_pend_d;
  logic [3:0]  decay_inc;
  logic        accept;

  // Output stage
  logic [30:0] bar_q, bar_d;
  logic [4:0]  peak_out_q, peak_out_d;
  logic        upd_q, upd_d;

`ifdef INDICATOR_PEAK_HOLD_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

  logic [4:0]  peak_q, peak_d;
  logic [7:0]  hold_q, hold_d;

  // Level segments plus a single marker segment at peak-1.
  function automatic logic [30:0] bar_encode(input logic [4:0] level,
                                             input logic [4:0] peak);
    logic [30:0] bar;
    // Shift of 31 wraps to zero in 31 bits, so the subtraction yields all ones.
    bar = (31'h1 << level) - 31'h1;
    if (peak != 5'd0) begin
      bar[peak - 5'd1] = 1'b1;
    end
    return bar;
  endfunction
`else
  // Level segments only.
  function automatic logic [30:0] bar_encode(input logic [4:0] level);
    logic [30:0] bar;
    bar = (31'h1 << level) - 31'h1;
    return bar;
  endfunction
`endif

  // Ready is a decode of the state register, so it is registered and drops
  // for exactly the UPDATE cycle after every accept.
  assign i_ready = (state_q == S_IDLE);
  assign accept  = i_ready & i_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic: handshake, update and tick processing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    level_d     = level_q;
    decay_d     = decay_q;
    // A tick seen while one is already pending is merged into it.
    tick_pend_d = tick_pend_q | i_tick;
    decay_inc   = decay_q + 4'd1;
`ifdef INDICATOR_PEAK_HOLD_EN
    peak_d      = peak_q;
    hold_d      = hold_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Handshake has priority; any pending tick waits until after UPDATE.
          pos_d   = i_position;
          state_d = S_UPDATE;
        end else if (tick_pend_q) begin
          // Pending tick is consumed here; a tick arriving this same cycle
          // is still merged into the one being consumed.
          tick_pend_d = 1'b0;
          if (decay_inc >= DECAY_LAST) begin
            decay_d = 4'd0;
            if (level_q != 5'd0) begin
              level_d = level_q - 5'd1;
            end
          end else begin
            decay_d = decay_inc;
          end
`ifdef INDICATOR_PEAK_HOLD_EN
          // Compare against the post-decay level so the marker can never
          // sit below the bar.
          if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end else if (peak_q > level_d) begin
            peak_d = peak_q - 5'd1;
          end
`endif
        end
      end

      S_UPDATE: begin
        // A position below the current level leaves everything untouched.
        if (pos_q >= level_q) begin
          level_d = pos_q;
          decay_d = 4'd0;
        end
`ifdef INDICATOR_PEAK_HOLD_EN
        if (pos_q >= peak_q) begin
          peak_d = pos_q;
          hold_d = HOLD_INIT;
        end
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output encoding: one cycle behind level/peak
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef INDICATOR_PEAK_HOLD_EN
    bar_d      = bar_encode(level_q, peak_q);
    peak_out_d = peak_q;
`else
    bar_d      = bar_encode(level_q);
    peak_out_d = level_q;
`endif
    upd_d = (bar_d != bar_q);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pos_q       <= 5'd0;
      level_q     <= 5'd0;
      decay_q     <= 4'd0;
      tick_pend_q <= 1'b0;
      bar_q       <= 31'd0;
      peak_out_q  <= 5'd0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      level_q     <= level_d;
      decay_q     <= decay_d;
      tick_pend_q <= tick_pend_d;
      bar_q       <= bar_d;
      peak_out_q  <= peak_out_d;
      upd_q       <= upd_d;
    end
  end

`ifdef INDICATOR_PEAK_HOLD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= 5'd0;
      hold_q <= 8'd0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end
`endif

  assign o_bar    = bar_q;
  assign o_peak   = peak_out_q;
  assign o_update = upd_q;

endmodule

// File: tb/tb_indicator_bar_driver.sv
module tb_indicator_bar_driver;

  localparam int HOLD  = 3;
  localparam int DECAY = 2;
`ifdef INDICATOR_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [4:0]  i_position = 5'd0;
  logic        i_tick = 1'b0;
  logic [30:0] o_bar;
  logic [4:0]  o_peak;
  logic        o_update;

  always #5 clk = ~clk;

  indicator_bar_driver #(
    .HOLD_TICKS (HOLD),
    .DECAY_TICKS(DECAY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_position(i_position),
    .i_tick    (i_tick),
    .o_bar     (o_bar),
    .o_peak    (o_peak),
    .o_update  (o_update)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: meter state as plain integers.
  int          m_level, m_peak, m_hold, m_decay;
  logic [30:0] m_last_bar;

  typedef struct packed {
    logic [30:0] bar;
    logic [4:0]  peak;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [30:0] model_bar(int lvl, int pk);
    logic [30:0] b;
    b = '0;
    for (int n = 0; n < 31; n++)
      if (n < lvl || (PEAK_EN && pk > 0 && n == pk - 1)) b[n] = 1'b1;
    return b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic m_emit();
    logic [30:0] b;
    b = model_bar(m_level, m_peak);
    if (b != m_last_bar) begin
      exp_q.push_back('{bar: b, peak: 5'(m_peak)});
      m_last_bar = b;
    end
  endtask

  task automatic m_reset();
    m_level = 0; m_peak = 0; m_hold = 0; m_decay = 0;
    m_last_bar = '0;
    exp_q.delete();
  endtask

  task automatic m_accept(int p);
    if (p >= m_level) begin
      m_level = p;
      m_decay = 0;
    end
    if (PEAK_EN) begin
      if (p >= m_peak) begin
        m_peak = p;
        m_hold = HOLD;
      end
    end else m_peak = m_level;
    m_emit();
  endtask

  task automatic m_tick();
    m_decay++;
    if (m_decay == DECAY) begin
      m_decay = 0;
      if (m_level > 0) m_level--;
    end
    if (PEAK_EN) begin
      if (m_hold > 0) m_hold--;
      else if (m_peak > m_level) m_peak--;
    end else m_peak = m_level;
    m_emit();
  endtask

  // Monitor: every o_update pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && o_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got bar %0h required no update", o_bar);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_bar", {1'b0, o_bar}, {1'b0, mon_e.bar});
        check("update_peak", 32'(o_peak), 32'(mon_e.peak));
      end
    end
  end

  task automatic check_now(string tag);
    @(negedge clk);
    check({tag, "_bar"}, {1'b0, o_bar}, {1'b0, model_bar(m_level, m_peak)});
    check({tag, "_peak"}, 32'(o_peak), 32'(m_peak));
  endtask

  task automatic do_accept(int p, bit with_tick);
    int guard;
    guard = 0;
    while (!i_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got i_ready 0 required 1 within 10 cycles");
      return;
    end
    i_valid = 1'b1; i_position = 5'(p); i_tick = with_tick;
    @(posedge clk); #1;
    i_valid = 1'b0; i_tick = 1'b0;
    check("ready_low_after_accept", 32'(i_ready), 32'd0);
    m_accept(p);
    if (with_tick) m_tick();
    @(posedge clk); #1;
    check("ready_back_high", 32'(i_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // burst=1 drives two back-to-back tick cycles, which merge into one.
  task automatic do_tick(bit burst);
    i_tick = 1'b1;
    @(posedge clk); #1;
    if (burst) begin
      @(posedge clk); #1;
    end
    i_tick = 1'b0;
    m_tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish required finish before 300000");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_r;
    int r;
    m_reset();
    // Reset held with a valid position present: nothing may be captured.
    reset = 1'b1; i_valid = 1'b1; i_position = 5'd20;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(i_ready), 32'd1);
    check("reset_bar", {1'b0, o_bar}, 32'd0);
    check("reset_peak", 32'(o_peak), 32'd0);
    check("reset_update", 32'(o_update), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_idle");

    // Single accept of 10.
    @(posedge clk); #1;
    do_accept(10, 1'b0);
    @(negedge clk);
    check("acc10_bar", {1'b0, o_bar}, 32'h0000_03FF);
    check("acc10_peak", 32'(o_peak), 32'd10);

    // Valid held high: accepts only on alternate cycles, no new updates.
    @(posedge clk); #1;
    i_valid = 1'b1; i_position = 5'd10;
    exp_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("alt_ready", 32'(i_ready), 32'(exp_r));
      if (exp_r) m_accept(10);
      exp_r = !exp_r;
    end
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_now("held_valid");

    // Decay and hold with no input.
    for (int t = 0; t < 6; t++) begin
      do_tick(1'b0);
      check_now("decay");
    end

    // Lower input after re-establishing 10.
    do_accept(10, 1'b0);
    do_accept(4, 1'b0);
    check_now("lower_input");
    do_tick(1'b0);
    check_now("lower_then_tick");

    // Tick together with a handshake.
    do_accept(12, 1'b1);
    check_now("tick_with_accept");
    for (int t = 0; t < 4; t++) begin
      do_tick(1'b0);
      check_now("after_simul");
    end

    // Merged back-to-back ticks.
    do_tick(1'b1);
    check_now("merged_tick");

    // Reset during UPDATE.
    i_valid = 1'b1; i_position = 5'd25;
    @(posedge clk); #1;
    i_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    check("midreset_ready", 32'(i_ready), 32'd1);
    check("midreset_bar", {1'b0, o_bar}, 32'd0);
    check("midreset_peak", 32'(o_peak), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_now("midreset_idle");

    // Position 5 then 2.
    do_accept(5, 1'b0);
    do_accept(2, 1'b0);
    @(negedge clk);
    check("acc5_2_bar", {1'b0, o_bar}, 32'h0000_001F);
    check("acc5_2_peak", 32'(o_peak), 32'd5);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) do_accept($urandom_range(0, 31), ($urandom_range(0, 3) == 0));
      else if (r <= 7) do_tick(1'b0);
      else if (r == 8) do_tick(1'b1);
      else begin
        repeat (3) @(posedge clk);
        #1;
      end
      if ((it % 4) == 0) check_now("random");
    end

    // Top and bottom of the scale.
    do_accept(31, 1'b0);
    check_now("full_scale");
    for (int t = 0; t < 70; t++) do_tick(1'b0);
    check_now("decayed_to_zero");

    repeat (6) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
